// File: rtl/route_prbs_checker.sv
// ---------------------------------------------------------------------------
// route_prbs_checker
//
// Receiver for on-silicon route validation. A PRBS7 (x^7 + x^6 + 1) pattern
// is launched across the routing arc under test. This block samples the far
// end, self-synchronises to the pattern, and reports lock and bit errors.
//
// Parameters
//   SYNC_LEN    consecutive good comparisons needed to declare lock (>=1)
//   WIN         lock-monitor window length in compared bits (power of 2, >=8)
//   LOSS_THRESH errors within one window that drop lock (1..WIN)
//   ERR_W       width of the saturating error counter
//
// Ports
//   CLK        in   clock, all state updates on the rising edge
//   LSR        in   synchronous active-high reset, overrides CE
//   CE         in   sample enable; when low no state advances
//   DIN        in   sampled route-under-test net
//   LOCKED     out  checker is synchronised and comparing
//   ERR_PULSE  out  one-cycle strobe per detected bit error
//   ERR_CNT    out  saturating total error count (cleared only by LSR)
//   BIT_CNT    out  saturating count of compared bits in LOCK
//                   (present only when ROUTE_PRBS_BITCNT_EN is defined)
//   DBG_STATE  out  current FSM state (0 FILL, 1 SEEK, 2 LOCK)
//
// Handshake: there is no valid/ready pair. Every cycle with CE high is one
// sample of DIN; cycles with CE low are ignored apart from ERR_PULSE
// returning to 0.
//
// Optional feature macro: ROUTE_PRBS_BITCNT_EN
// ---------------------------------------------------------------------------
module route_prbs_checker #(
  parameter int SYNC_LEN    = 16,
  parameter int WIN         = 64,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 16
) (
  input  logic             CLK,
  input  logic             LSR,
  input  logic             CE,
  input  logic             DIN,
  output logic             LOCKED,
  output logic             ERR_PULSE,
  output logic [ERR_W-1:0] ERR_CNT,
`ifdef ROUTE_PRBS_BITCNT_EN
  output logic [31:0]      BIT_CNT,
`endif
  output logic [1:0]       DBG_STATE
);

  localparam int GW = $clog2(SYNC_LEN + 1);
  localparam int WW = $clog2(WIN + 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_SEEK = 2'd1,
    S_LOCK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       sr_q, sr_d;
  logic [2:0]       fill_q, fill_d;
  logic [GW-1:0]    good_q, good_d;
  logic [WW-1:0]    win_cnt_q, win_cnt_d;
  logic [WW-1:0]    win_err_q, win_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             locked_q, locked_d;
`ifdef ROUTE_PRBS_BITCNT_EN
  logic [31:0]      bit_cnt_q, bit_cnt_d;
`endif

  // Predicted next bit from the 7-bit history, and comparison against DIN.
  logic          pred;
  logic          mismatch;
  logic [WW-1:0] win_err_inc;

  assign pred        = sr_q[6] ^ sr_q[5];
  assign mismatch    = DIN ^ pred;
  // Window error count including the current bit's error.
  assign win_err_inc = win_err_q + WW'(mismatch);

  // -------------------------------------------------------------------------
  // State register (all sequential state lives here)
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (LSR) begin
      state_q     <= S_FILL;
      sr_q        <= '0;
      fill_q      <= '0;
      good_q      <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
`ifdef ROUTE_PRBS_BITCNT_EN
      bit_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      good_q      <= good_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
`ifdef ROUTE_PRBS_BITCNT_EN
      bit_cnt_q   <= bit_cnt_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    good_d      = good_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
`ifdef ROUTE_PRBS_BITCNT_EN
    bit_cnt_d   = bit_cnt_q;
`endif

    if (CE) begin
      case (state_q)
        S_FILL: begin
          sr_d = {sr_q[5:0], DIN};
          if (fill_q == 3'd6) begin
            state_d = S_SEEK;
            fill_d  = '0;
            good_d  = '0;
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end

        S_SEEK: begin
          sr_d = {sr_q[5:0], DIN};
          // An all-zero history predicts 0 forever; refusing to count it
          // keeps a stuck-at-0 net from ever locking.
          if (!mismatch && (sr_q != '0)) begin
            if (good_q == GW'(SYNC_LEN - 1)) begin
              state_d   = S_LOCK;
              good_d    = '0;
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              good_d = good_q + GW'(1);
            end
          end else begin
            good_d = '0;
          end
        end

        S_LOCK: begin
          // Free-running generator: a flipped input bit cannot corrupt the
          // history, so each flipped bit yields exactly one error.
          sr_d        = {sr_q[5:0], pred};
          err_pulse_d = mismatch;
          if (mismatch && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
`ifdef ROUTE_PRBS_BITCNT_EN
          if (bit_cnt_q != 32'hFFFF_FFFF) begin
            bit_cnt_d = bit_cnt_q + 32'd1;
          end
`endif
          if (win_cnt_q == WW'(WIN - 1)) begin
            if (win_err_inc >= WW'(LOSS_THRESH)) begin
              state_d = S_FILL;
              fill_d  = '0;
            end
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WW'(1);
            win_err_d = win_err_inc;
          end
        end

        default: begin
          state_d = S_FILL;
          fill_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == S_LOCK);
  end

  // -------------------------------------------------------------------------
  // Outputs (all driven from registers)
  // -------------------------------------------------------------------------
  always_comb begin
    LOCKED    = locked_q;
    ERR_PULSE = err_pulse_q;
    ERR_CNT   = err_cnt_q;
    DBG_STATE = state_q;
`ifdef ROUTE_PRBS_BITCNT_EN
    BIT_CNT   = bit_cnt_q;
`endif
  end

endmodule

// File: tb/tb_route_prbs_checker.sv
module tb_route_prbs_checker;

  localparam int EW = 22;  // {locked, err_pulse, err_cnt[15:0], err_cnt4[3:0]}

  logic        clk = 1'b0;
  logic        lsr;
  logic        ce;
  logic        din;
  logic        locked,  err_pulse;
  logic [15:0] err_cnt;
  logic [1:0]  dbg_state;
  logic        locked4, err_pulse4;
  logic [3:0]  err_cnt4;
  logic [1:0]  dbg_state4;
`ifdef ROUTE_PRBS_BITCNT_EN
  logic [31:0] bit_cnt, bit_cnt4;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [EW-1:0] exp_q[$];
  logic [6:0]    gen_q;

  route_prbs_checker dut (
    .CLK(clk), .LSR(lsr), .CE(ce), .DIN(din),
    .LOCKED(locked), .ERR_PULSE(err_pulse), .ERR_CNT(err_cnt),
`ifdef ROUTE_PRBS_BITCNT_EN
    .BIT_CNT(bit_cnt),
`endif
    .DBG_STATE(dbg_state)
  );

  route_prbs_checker #(.ERR_W(4)) dut4 (
    .CLK(clk), .LSR(lsr), .CE(ce), .DIN(din),
    .LOCKED(locked4), .ERR_PULSE(err_pulse4), .ERR_CNT(err_cnt4),
`ifdef ROUTE_PRBS_BITCNT_EN
    .BIT_CNT(bit_cnt4),
`endif
    .DBG_STATE(dbg_state4)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- drivers
  // Apply one cycle of inputs, then return #1 after the rising edge so the
  // caller samples settled registered outputs.
  task automatic drive_sample(input logic d, input logic c, input logic r);
    din = d;
    ce  = c;
    lsr = r;
    @(posedge clk);
    #1;
  endtask

  // Reference PRBS7 source: b[n] = b[n-7] ^ b[n-6].
  task automatic next_prbs(output logic b);
    b     = gen_q[6] ^ gen_q[5];
    gen_q = {gen_q[5:0], b};
  endtask

  task automatic apply_reset();
    drive_sample(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    drive_sample(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    gen_q = 7'h7F;
  endtask

  function automatic logic [EW-1:0] mk_exp(logic l, logic p, int cnt);
    logic [15:0] c16;
    logic [3:0]  c4;
    c16 = 16'(cnt);
    c4  = (cnt > 15) ? 4'hF : 4'(cnt);
    return {l, p, c16, c4};
  endfunction

  function automatic logic [EW-1:0] observed();
    return {locked, err_pulse, err_cnt, err_cnt4};
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [EW-1:0] e;
    exp_q.push_back(mk_exp(1'b0, 1'b0, 0));
    drive_sample(1'b1, 1'b1, 1'b1);
    e = exp_q.pop_front();
    tests_run++;
    if (observed() !== e) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%h exp=%h", observed(), e);
    end
    tests_run++;
    if (dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
`ifdef ROUTE_PRBS_BITCNT_EN
    tests_run++;
    if (bit_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt);
    end
`endif
  endtask

  // Clean stream: lock after sample index 22 (23rd sample), no errors.
  task automatic test_clean_lock();
    logic b;
    logic [EW-1:0] e;
    apply_reset();
    for (int n = 0; n < 1000; n++) begin
      next_prbs(b);
      exp_q.push_back(mk_exp(n >= 22, 1'b0, 0));
      drive_sample(b, 1'b1, 1'b0);
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL clean_lock n=%0d got=%h exp=%h", n, observed(), e);
      end
    end
  endtask

  // Invert n_err bits at indices 30,40,50,60, all inside the first window
  // (LOCK samples 23..86). Four errors drop lock after sample 86 and the
  // checker relocks after sample 109 (23 clean samples later).
  task automatic test_window_errors(input int n_err);
    logic b;
    logic l, p;
    int k;
    logic [EW-1:0] e;
    apply_reset();
    for (int n = 0; n < 200; n++) begin
      next_prbs(b);
      p = (n >= 30) && (n < 30 + 10 * n_err) && ((n - 30) % 10 == 0);
      if (p) b = ~b;
      k = 0;
      for (int i = 0; i < n_err; i++) if (30 + 10 * i <= n) k++;
      if (n_err >= 4) l = ((n >= 22) && (n < 86)) || (n >= 109);
      else            l = (n >= 22);
      exp_q.push_back(mk_exp(l, p, k));
      drive_sample(b, 1'b1, 1'b0);
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL window_errors%0d n=%0d got=%h exp=%h", n_err, n, observed(), e);
      end
    end
  endtask

  task automatic test_stuck();
    logic [EW-1:0] e;
    apply_reset();
    for (int n = 0; n < 1000; n++) begin
      exp_q.push_back(mk_exp(1'b0, 1'b0, 0));
      drive_sample(n >= 500, 1'b1, 1'b0);
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL stuck n=%0d got=%h exp=%h", n, observed(), e);
      end
    end
  endtask

  // Lock, then invert samples 23..86 (one full window). The 4-bit counter
  // saturates at 15 while the 16-bit counter reaches 64; ERR_PULSE fires on
  // every inverted sample. With duty>1, CE is high one cycle in `duty`.
  task automatic test_saturation(input int duty);
    logic b;
    int n;
    int k;
    logic [EW-1:0] e, last;
    apply_reset();
    n    = 0;
    last = mk_exp(1'b0, 1'b0, 0);
    for (int c = 0; c < 120 * duty; c++) begin
      if (c % duty == 0) begin
        next_prbs(b);
        if (n >= 23 && n <= 86) b = ~b;
        k = (n < 23) ? 0 : (((n > 86) ? 86 : n) - 22);
        e = mk_exp(((n >= 22) && (n < 86)) || (n >= 109), (n >= 23) && (n <= 86), k);
        exp_q.push_back(e);
        last     = e;
        last[20] = 1'b0;
        drive_sample(b, 1'b1, 1'b0);
        n++;
      end else begin
        exp_q.push_back(last);
        drive_sample(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL saturation_duty%0d cycle=%0d got=%h exp=%h", duty, c, observed(), e);
      end
    end
  endtask

  // Errors at 25 and 26, then LSR together with another error at 27.
  task automatic test_lsr_mid_lock();
    logic b;
    logic p;
    logic [EW-1:0] e;
    apply_reset();
    for (int n = 0; n < 27; n++) begin
      next_prbs(b);
      p = (n == 25) || (n == 26);
      if (p) b = ~b;
      exp_q.push_back(mk_exp(n >= 22, p, int'(n >= 25) + int'(n >= 26)));
      drive_sample(b, 1'b1, 1'b0);
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL lsr_prelock n=%0d got=%h exp=%h", n, observed(), e);
      end
    end
`ifdef ROUTE_PRBS_BITCNT_EN
    tests_run++;
    if (bit_cnt !== 32'd4) begin
      tests_failed++;
      $display("FAIL bit_cnt_locked got=%0d exp=4", bit_cnt);
    end
`endif
    next_prbs(b);
    exp_q.push_back(mk_exp(1'b0, 1'b0, 0));
    drive_sample(~b, 1'b1, 1'b1);
    e = exp_q.pop_front();
    tests_run++;
    if (observed() !== e) begin
      tests_failed++;
      $display("FAIL lsr_clear got=%h exp=%h", observed(), e);
    end
    tests_run++;
    if (dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL lsr_state got=%0d exp=0", dbg_state);
    end
`ifdef ROUTE_PRBS_BITCNT_EN
    tests_run++;
    if (bit_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL lsr_bit_cnt got=%0d exp=0", bit_cnt);
    end
`endif
    // Fresh relock after the reset.
    gen_q = 7'h7F;
    for (int n = 0; n < 30; n++) begin
      next_prbs(b);
      exp_q.push_back(mk_exp(n >= 22, 1'b0, 0));
      drive_sample(b, 1'b1, 1'b0);
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL lsr_relock n=%0d got=%h exp=%h", n, observed(), e);
      end
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    lsr   = 1'b1;
    ce    = 1'b0;
    din   = 1'b0;
    gen_q = 7'h7F;
    test_reset();
    test_clean_lock();
    test_window_errors(1);
    test_window_errors(3);
    test_window_errors(4);
    test_stuck();
    test_saturation(1);
    test_saturation(3);
    test_lsr_mid_lock();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
